fetch_ctrl: RTL and testbench

Fetch sequencer for the MIPS fetch stage. It owns the program counter and issues read requests to the 128-word instruction memory (1-cycle read latency, rd_en/rd_addr in, data_out/valid_out back). Returned instructions go into a 2-entry output buffer with a valid/ready handshake toward decode. It also handles branch/jump redirects and enable/stall.

---
 rtl/fetch_ctrl.sv | 170 +++++++++++++++++
 tb/tb_fetch_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Fetch sequencer for the MIPS fetch stage. Owns the program counter, issues
// single-word reads to a 128-word instruction memory with 1-cycle read
// latency, and queues returned instructions in a 2-entry output buffer
// with a valid/ready handshake toward decode. Handles branch/jump redirects
// and fetch enable.
//
// Ports:
//   CLK, RST_N          clock; synchronous active-low reset
//   en                  fetch enable (0 stops new requests)
//   redir_valid/pc      redirect request and target byte address
//   mem_rd_en/addr      read request to instruction memory (word address)
//   mem_data/valid      read response from instruction memory
//   out_valid/ready     handshake toward decode for the buffer head
//   out_instr/pc        head instruction and its byte PC
// -----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int          ADDR_W   = 7,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              en,
    input  logic              redir_valid,
    input  logic [31:0]       redir_pc,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [31:0]       mem_data,
    input  logic              mem_valid,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] REDIR = 2'd2;

    localparam logic [2:0] DEPTH3 = 3'(DEPTH);

    logic [1:0]  state;
    logic [1:0]  stateNext;
    logic [31:0] pc;
    logic [31:0] reqPc;
    logic        inflight;
    logic        drop;
    logic [1:0]  count;
    logic        rdPtr;
    logic        wrPtr;
    logic [31:0] bufInstr [2];
    logic [31:0] bufPc    [2];

    logic response;
    logic push;
    logic pop;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    // NOTE: every variable written in always_comb gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    stateNext = (en && !redir_valid) ? RUN : IDLE;
            RUN,
            REDIR:   begin
                if (redir_valid)
                    stateNext = REDIR;
                else
                    stateNext = en ? RUN : IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Credit check uses the registered occupancy only; a pop in the same cycle
    // does not free a slot until the next cycle.
    assign mem_rd_en   = (state == RUN) && en && !redir_valid &&
                         (({1'b0, count} + {2'b00, inflight}) < DEPTH3);
    assign mem_rd_addr = pc[ADDR_W+1:2];

    // A response only counts when a request is actually outstanding. It is
    // discarded if an earlier redirect marked it stale or a redirect is
    // happening right now.
    assign response = mem_valid && inflight;
    assign push     = response && !drop && !redir_valid;
    assign pop      = out_valid && out_ready;

    assign out_valid = (count != 2'd0);
    assign out_instr = out_valid ? bufInstr[rdPtr] : 32'h0;
    assign out_pc    = out_valid ? bufPc[rdPtr]    : 32'h0;

    // ---------------------------------------------------------------------
    // Control state
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            reqPc    <= RESET_PC;
            inflight <= 1'b0;
            drop     <= 1'b0;
            count    <= 2'd0;
            rdPtr    <= 1'b0;
            wrPtr    <= 1'b0;
        end else begin
            state <= stateNext;

            if (redir_valid)
                pc <= redir_pc & 32'hFFFF_FFFC;
            else if (mem_rd_en)
                pc <= pc + 32'd4;

            if (mem_rd_en) begin
                inflight <= 1'b1;
                reqPc    <= pc;
            end else if (response) begin
                inflight <= 1'b0;
            end

            // A response arriving in the redirect cycle is dropped directly;
            // drop only covers a response that is still on its way.
            if (response)
                drop <= 1'b0;
            else if (redir_valid && inflight)
                drop <= 1'b1;

            // A redirect flushes everything that is not being popped now.
            if (redir_valid) begin
                count <= 2'd0;
                rdPtr <= 1'b0;
                wrPtr <= 1'b0;
            end else begin
                if (push)
                    wrPtr <= ~wrPtr;
                if (pop)
                    rdPtr <= ~rdPtr;
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end

    // ---------------------------------------------------------------------
    // Buffer storage
    // ---------------------------------------------------------------------
    // NOTE: the storage array is not reset; out_instr/out_pc are gated by
    // out_valid, so stale contents are never visible.
    always_ff @(posedge CLK) begin
        if (push) begin
            bufInstr[wrPtr] <= mem_data;
            bufPc[wrPtr]    <= reqPc;
        end
    end

    // Overflow is impossible by construction of the credit check.
    assert property (@(posedge CLK) disable iff (!RST_N) {1'b0, count} <= DEPTH3)
        else $error("fetch_ctrl: buffer occupancy above depth");

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
//
// Self-checking bench for fetch_ctrl. A behavioural 1-cycle-latency memory
// answers read requests. A negedge monitor keeps a reference stream: each
// issue is checked against the expected next PC and the expected
// {instruction, pc} is queued; each pop toward decode is compared against
// the queue head. Redirects and reset restart the reference stream. A
// directed sequence in the initial block covers reset, latency, backpressure,
// redirects, PC wrap, enable drop and reset mid-stream.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        en;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        mem_rd_en;
    logic [6:0]  mem_rd_addr;
    logic [31:0] mem_data;
    logic        mem_valid;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    always #5 CLK = ~CLK;

    fetch_ctrl dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .en         (en),
        .redir_valid(redir_valid),
        .redir_pc   (redir_pc),
        .mem_rd_en  (mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_data   (mem_data),
        .mem_valid  (mem_valid),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } itemT;

    logic [31:0] mem [128];
    itemT        expQ [$];
    logic [31:0] expIssuePc;
    logic [31:0] lastPc;
    int          popCount   = 0;
    int          numChecks  = 0;
    int          numFails   = 0;

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Instruction memory: one-cycle read latency, junk data when idle.
    always @(posedge CLK) begin
        mem_valid <= mem_rd_en;
        mem_data  <= mem_rd_en ? mem[mem_rd_addr] : 32'hDEAD_BEEF;
    end

    // Reference stream monitor.
    always @(negedge CLK) begin
        itemT head;
        bit   popped;
        popped = 1'b0;
        if (RST_N !== 1'b1) begin
            expQ.delete();
            expIssuePc = 32'h0;
        end else begin
            if (out_valid && out_ready) begin
                popped = 1'b1;
                popCount++;
                lastPc = out_pc;
                if (expQ.size() == 0) begin
                    check("unexpected_pop", 32'(out_valid), 32'd0);
                end else begin
                    head = expQ.pop_front();
                    check("out_pc", out_pc, head.pc);
                    check("out_instr", out_instr, head.instr);
                end
            end
            if (mem_rd_en) begin
                check("rd_addr", 32'(mem_rd_addr), 32'(expIssuePc[8:2]));
                check("credit", 32'((expQ.size() + int'(popped)) < 2), 32'd1);
                expQ.push_back({mem[expIssuePc[8:2]], expIssuePc});
                expIssuePc = expIssuePc + 32'd4;
            end
            if (redir_valid) begin
                expQ.delete();
                expIssuePc = {redir_pc[31:2], 2'b00};
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic waitPops(input int n, input int budget, input string tag);
        int target;
        int cyc;
        target = popCount + n;
        cyc    = 0;
        while (popCount < target && cyc < budget) begin
            tick();
            cyc++;
        end
        check(tag, 32'(popCount >= target), 32'd1);
    endtask

    task automatic waitIssue(input string tag);
        int cyc;
        cyc = 0;
        while (mem_rd_en !== 1'b1 && cyc < 10) begin
            tick();
            cyc++;
        end
        check(tag, 32'(mem_rd_en), 32'd1);
    endtask

    task automatic waitValid(input string tag);
        int cyc;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 10) begin
            tick();
            cyc++;
        end
        check(tag, 32'(out_valid), 32'd1);
    endtask

    initial begin
        RST_N       = 1'b0;
        en          = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = 32'h0;
        out_ready   = 1'b0;
        for (int i = 0; i < 128; i++)
            mem[i] = 32'hC0DE_0000 | 32'(i);
        mem[0] = 32'h11;
        mem[1] = 32'h22;
        mem[2] = 32'h33;
        mem[3] = 32'h44;

        // Reset state
        repeat (2) tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_pc", dut.pc, 32'h0);

        // Sequential fetch and first-fetch latency
        RST_N     = 1'b1;
        en        = 1'b1;
        out_ready = 1'b1;
        tick();
        check("first_rd_en", 32'(mem_rd_en), 32'd1);
        check("first_addr", 32'(mem_rd_addr), 32'd0);
        tick();
        check("lat_no_valid", 32'(out_valid), 32'd0);
        check("second_rd_en", 32'(mem_rd_en), 32'd1);
        check("second_addr", 32'(mem_rd_addr), 32'd1);
        tick();
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_pc", out_pc, 32'h0);
        check("first_instr", out_instr, 32'h11);
        waitPops(4, 20, "seq_pops");

        // Backpressure fills the buffer and stops issue
        out_ready = 1'b0;
        repeat (6) tick();
        check("bp_count", 32'(dut.count), 32'd2);
        check("bp_rd_en", 32'(mem_rd_en), 32'd0);
        check("bp_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        waitPops(6, 30, "bp_resume");

        // Redirect to 0x43 (aligned to 0x40) while a request is in flight
        waitIssue("redir_pre_issue");
        tick();
        check("redir_inflight", 32'(dut.inflight), 32'd1);
        redir_valid = 1'b1;
        redir_pc    = 32'h43;
        #1;
        check("redir_no_issue", 32'(mem_rd_en), 32'd0);
        tick();
        redir_valid = 1'b0;
        check("redir_flushed", 32'(out_valid), 32'd0);
        check("redir_gap", 32'(mem_rd_en), 32'd0);
        tick();
        check("redir_rd_en", 32'(mem_rd_en), 32'd1);
        check("redir_addr", 32'(mem_rd_addr), 32'd16);
        waitValid("redir_valid_out");
        check("redir_out_pc", out_pc, 32'h40);
        check("redir_out_instr", out_instr, 32'hC0DE_0010);

        // Back-to-back redirects over a full buffer: only 0x80 is fetched
        out_ready = 1'b0;
        repeat (6) tick();
        check("b2b_full", 32'(dut.count), 32'd2);
        redir_valid = 1'b1;
        redir_pc    = 32'h40;
        tick();
        check("b2b_flush", 32'(out_valid), 32'd0);
        redir_pc = 32'h80;
        tick();
        redir_valid = 1'b0;
        check("b2b_still_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        waitValid("b2b_valid_out");
        check("b2b_out_pc", out_pc, 32'h80);
        waitPops(3, 20, "b2b_pops");

        // Word-address wrap at the top of instruction memory
        redir_valid = 1'b1;
        redir_pc    = 32'h1FC;
        tick();
        redir_valid = 1'b0;
        tick();
        check("wrap_addr127", 32'(mem_rd_addr), 32'd127);
        waitValid("wrap_valid0");
        check("wrap_pc0", out_pc, 32'h1FC);
        tick();
        waitValid("wrap_valid1");
        check("wrap_pc1", out_pc, 32'h200);
        check("wrap_instr1", out_instr, 32'h11);
        waitPops(3, 20, "wrap_pops");
        check("wrap_last_pc_seen", 32'(lastPc >= 32'h200), 32'd1);

        // Enable drop with a request outstanding
        waitIssue("en0_pre_issue");
        tick();
        en = 1'b0;
        #1;
        check("en0_no_issue_now", 32'(mem_rd_en), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("en0_no_issue", 32'(mem_rd_en), 32'd0);
        end
        check("en0_drained", 32'(expQ.size()), 32'd0);
        check("en0_empty", 32'(out_valid), 32'd0);

        // Reset in the middle of a stream
        en        = 1'b1;
        out_ready = 1'b0;
        tick();
        waitIssue("mid_rst_pre_issue");
        RST_N = 1'b0;
        tick();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_pc", dut.pc, 32'h0);
        check("mid_rst_rd_en", 32'(mem_rd_en), 32'd0);
        RST_N = 1'b1;
        tick();
        check("post_rst_ignored", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        waitValid("post_rst_valid");
        check("post_rst_pc", out_pc, 32'h0);
        check("post_rst_instr", out_instr, 32'h11);
        waitPops(3, 20, "post_rst_pops");

        en = 1'b0;
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
